// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU request scheduler: opcodes, fixed ALU latency and the
// in-flight tag that travels alongside each operation.
package alu_ctrl_pkg;

  localparam int ALU_LATENCY = 2;
  localparam int MAX_IDW     = 3;

  typedef enum logic [2:0] {
    ADD     = 3'd0,
    SUB_BA  = 3'd1,
    MUL     = 3'd2,
    NOT_A   = 3'd3,
    XOR     = 3'd4,
    ABS_A   = 3'd5,
    HSUB    = 3'd6,
    ILLEGAL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
    logic               illegal;
  } alu_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts one past ptr and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          hold,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (!hold) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx[IW-1:0];
          grant[idx]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one pipelined ALU among NREQ requesters: round-robin issue, registered
// ALU drive, and a tag pipe that labels each returning result with its requester.
module alu_rr_sched
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int ALU_LAT = ALU_LATENCY
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*8-1:0] req_data_a_i,
  input  logic [NREQ*8-1:0] req_data_b_i,
  input  logic [NREQ*3-1:0] req_inst_i,
  input  logic              hold_i,
  output logic [7:0]        alu_data_a_o,
  output logic [7:0]        alu_data_b_o,
  output logic [2:0]        alu_inst_o,
  input  logic [15:0]       alu_data_i,
  output logic              rsp_valid_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [15:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_valid;
  logic [7:0]     sel_a;
  logic [7:0]     sel_b;
  alu_op_e        sel_op;
  alu_tag_t       issue_tag;
  alu_tag_t       tag_pipe [ALU_LAT+1];

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req         (req_valid_i),
    .ptr         (rr_ptr),
    .hold        (hold_i),
    .grant       (req_ready_o),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The grant is only ever given to a valid requester, so grant_valid is the handshake.
  always_comb begin
    sel_a     = req_data_a_i[8*grant_idx +: 8];
    sel_b     = req_data_b_i[8*grant_idx +: 8];
    sel_op    = alu_op_e'(req_inst_i[3*grant_idx +: 3]);
    issue_tag = '0;
    issue_tag.valid            = grant_valid;
    issue_tag.id[IDW-1:0]      = grant_idx;
    issue_tag.illegal          = grant_valid && (sel_op == ILLEGAL);
  end

  // NOTE: the tag pipe is reset (not just the data path) so that a reset mid-operation
  // cannot leave stale valid tags that would emit phantom responses.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr       <= IDW'(NREQ-1);
      alu_data_a_o <= '0;
      alu_data_b_o <= '0;
      alu_inst_o   <= '0;
      for (int i = 0; i <= ALU_LAT; i++) tag_pipe[i] <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous cycle's values.
      alu_data_a_o <= grant_valid ? sel_a : 8'h00;
      alu_data_b_o <= grant_valid ? sel_b : 8'h00;
      alu_inst_o   <= grant_valid ? sel_op : ADD;
      if (grant_valid) rr_ptr <= grant_idx;
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i <= ALU_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      rsp_valid_o <= tag_pipe[ALU_LAT].valid;
      if (tag_pipe[ALU_LAT].valid) begin
        rsp_id_o   <= tag_pipe[ALU_LAT].id[IDW-1:0];
        rsp_err_o  <= tag_pipe[ALU_LAT].illegal;
        rsp_data_o <= tag_pipe[ALU_LAT].illegal ? 16'h0000 : alu_data_i;
      end
    end
  end

  always_comb begin
    busy_o = rsp_valid_o;
    for (int i = 0; i <= ALU_LAT; i++) busy_o = busy_o | tag_pipe[i].valid;
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed plus random bench for alu_rr_sched with a 2-cycle ALU behavioural model
// and a cycle-indexed scoreboard of expected responses.
module tb_alu_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk_p_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*8-1:0] req_data_a_i = '0;
  logic [NREQ*8-1:0] req_data_b_i = '0;
  logic [NREQ*3-1:0] req_inst_i = '0;
  logic              hold_i = 1'b0;
  logic [7:0]        alu_data_a_o;
  logic [7:0]        alu_data_b_o;
  logic [2:0]        alu_inst_o;
  logic [15:0]       alu_data_i = '0;
  logic              rsp_valid_o;
  logic [IDW-1:0]    rsp_id_o;
  logic [15:0]       rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;

  alu_rr_sched #(.NREQ(NREQ)) dut (
    .clk_p_i      (clk_p_i),
    .reset_n_i    (reset_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_a_i (req_data_a_i),
    .req_data_b_i (req_data_b_i),
    .req_inst_i   (req_inst_i),
    .hold_i       (hold_i),
    .alu_data_a_o (alu_data_a_o),
    .alu_data_b_o (alu_data_b_o),
    .alu_inst_o   (alu_inst_o),
    .alu_data_i   (alu_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic signed [15:0] d;
    logic [7:0] na;
    na = 8'd0 - a;
    d  = $signed(16'(b) - 16'(a));
    case (op)
      3'd0:    return 16'(a) + 16'(b);
      3'd1:    return 16'(b) - 16'(a);
      3'd2:    return 16'(a) * 16'(b);
      3'd3:    return {8'h00, ~a};
      3'd4:    return {8'h00, a ^ b};
      3'd5:    return {8'h00, a[7] ? na : a};
      3'd6:    return 16'(d >>> 1);
      default: return 16'hDEAD;
    endcase
  endfunction

  // External ALU: registered inputs, registered output.
  logic [7:0] s_a, s_b;
  logic [2:0] s_op;
  always @(posedge clk_p_i) begin
    s_a        <= alu_data_a_o;
    s_b        <= alu_data_b_o;
    s_op       <= alu_inst_o;
    alu_data_i <= alu_fn(s_a, s_b, s_op);
  end

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Requester state and scoreboard (slot = due cycle mod 8)
  logic       pend_v  [NREQ];
  logic [7:0] pend_a  [NREQ];
  logic [7:0] pend_b  [NREQ];
  logic [2:0] pend_op [NREQ];
  logic       sticky = 1'b0;
  logic       m_hold = 1'b0;
  int         m_ptr  = NREQ-1;
  logic       exp_v    [8];
  logic [1:0] exp_id   [8];
  logic [15:0] exp_data[8];
  logic       exp_err  [8];
  logic [1:0]  last_id   = '0;
  logic [15:0] last_data = '0;
  logic        last_err  = 1'b0;
  logic [7:0]  m_alu_a = '0, m_alu_b = '0;
  logic [2:0]  m_alu_op = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_v[i] = 1'b0;
    m_ptr     = NREQ-1;
    last_id   = '0;
    last_data = '0;
    last_err  = 1'b0;
    m_alu_a   = '0;
    m_alu_b   = '0;
    m_alu_op  = '0;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    pend_v[i]  = 1'b1;
    pend_a[i]  = a;
    pend_b[i]  = b;
    pend_op[i] = op;
  endtask

  // One clock cycle: drive, check everything visible now, advance the model.
  task automatic step();
    int  g;
    int  s;
    int  idx;
    logic ebusy;
    logic [NREQ-1:0] eready;
    for (int i = 0; i < NREQ; i++) begin
      req_valid_i[i]        = pend_v[i];
      req_data_a_i[8*i +: 8] = pend_a[i];
      req_data_b_i[8*i +: 8] = pend_b[i];
      req_inst_i[3*i +: 3]   = pend_op[i];
    end
    hold_i = m_hold;
    #1;
    s = cyc % 8;
    chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_v[s]));
    if (exp_v[s]) begin
      last_id   = exp_id[s];
      last_data = exp_data[s];
      last_err  = exp_err[s];
    end
    chk("rsp_id", 32'(rsp_id_o), 32'(last_id));
    chk("rsp_data", 32'(rsp_data_o), 32'(last_data));
    chk("rsp_err", 32'(rsp_err_o), 32'(last_err));
    ebusy = 1'b0;
    for (int k = 0; k < 4; k++) ebusy |= exp_v[(cyc + k) % 8];
    chk("busy", 32'(busy_o), 32'(ebusy));
    chk("alu_a", 32'(alu_data_a_o), 32'(m_alu_a));
    chk("alu_b", 32'(alu_data_b_o), 32'(m_alu_b));
    chk("alu_inst", 32'(alu_inst_o), 32'(m_alu_op));
    exp_v[s] = 1'b0;

    g = -1;
    if (!m_hold)
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && pend_v[idx]) g = idx;
      end
    eready = '0;
    if (g >= 0) eready[g] = 1'b1;
    chk("req_ready", 32'(req_ready_o), 32'(eready));

    if (g >= 0) begin
      s = (cyc + 4) % 8;
      exp_v[s]    = 1'b1;
      exp_id[s]   = 2'(g);
      exp_err[s]  = (pend_op[g] == 3'd7);
      exp_data[s] = exp_err[s] ? 16'h0000 : alu_fn(pend_a[g], pend_b[g], pend_op[g]);
      m_alu_a  = pend_a[g];
      m_alu_b  = pend_b[g];
      m_alu_op = pend_op[g];
      m_ptr    = g;
      if (!sticky) pend_v[g] = 1'b0;
    end else begin
      m_alu_a  = '0;
      m_alu_b  = '0;
      m_alu_op = '0;
    end
    @(posedge clk_p_i);
    @(negedge clk_p_i);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    clear_pend();
    req_valid_i = '0;
    m_hold      = 1'b0;
    hold_i      = 1'b0;
    reset_n_i   = 1'b0;
    #1;
    chk("rst_alu", {13'd0, alu_data_a_o, alu_data_b_o, alu_inst_o}, 32'd0);
    chk("rst_rsp", {13'd0, rsp_valid_o, rsp_id_o, rsp_data_o}, 32'd0);
    chk("rst_err_busy", {30'd0, rsp_err_o, busy_o}, 32'd0);
    clear_model();
    @(posedge clk_p_i);
    @(posedge clk_p_i);
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0;
    end
    clear_model();
    @(negedge clk_p_i);
    do_reset();

    // 1: single ADD from requester 0
    run(2);
    set_req(0, 8'h05, 8'h03, 3'd0);
    run(6);

    // 2: all requesters continuously valid, MUL
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h10, 3'd2);
    sticky = 1'b1;
    run(8);
    sticky = 1'b0;
    clear_pend();
    run(5);

    // 3: illegal opcode from requester 2, then 4: hold while ops are in flight
    set_req(2, 8'hFF, 8'h01, 3'd7);
    run(1);
    set_req(1, 8'h11, 8'h22, 3'd4);
    set_req(3, 8'h80, 8'h00, 3'd5);
    m_hold = 1'b1;
    run(3);
    m_hold = 1'b0;
    run(7);

    // 5: SUB_BA then HSUB with the same operands
    set_req(0, 8'h05, 8'h03, 3'd1);
    run(1);
    set_req(0, 8'h05, 8'h03, 3'd6);
    run(6);

    // Random traffic with occasional hold
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && $urandom_range(0, 2) == 0)
          set_req(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      m_hold = ($urandom_range(0, 7) == 0);
      step();
    end
    m_hold = 1'b0;
    clear_pend();
    run(6);

    // 6: reset one cycle after three back-to-back issues
    set_req(0, 8'h01, 8'h02, 3'd0);
    set_req(1, 8'h03, 8'h04, 3'd0);
    set_req(2, 8'h05, 8'h06, 3'd0);
    run(4);
    do_reset();
    run(5);
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h07, 8'h01, 3'd0);
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Shares one pipelined 8-bit ALU (registered inputs and registered output, 2-cycle internal latency) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on the request side.
- Registered drive of the ALU inputs; in-flight tracking that tags each result with its requester ID.
- Sits between client blocks and the ALU instance; the ALU itself is outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester ID width
- ALU_LAT, 2, cycles from ALU input pins to ALU output valid; fixed by the ALU

Ports:
- clk_p_i  input  1  clock, rising edge
- reset_n_i  input  1  reset, asynchronous, active-low
- req_valid_i  input  NREQ  request valid per requester
- req_ready_o  output  NREQ  request accepted this cycle (one-hot or zero)
- req_data_a_i  input  NREQ*8  operand A, requester i at [8i+7:8i]
- req_data_b_i  input  NREQ*8  operand B, same packing
- req_inst_i  input  NREQ*3  opcode, requester i at [3i+2:3i]
- hold_i  input  1  1 = issue no new grants
- alu_data_a_o  output  8  to ALU operand A, registered
- alu_data_b_o  output  8  to ALU operand B, registered
- alu_inst_o  output  3  to ALU opcode, registered
- alu_data_i  input  16  ALU result
- rsp_valid_o  output  1  single-cycle result pulse, registered
- rsp_id_o  output  IDW  requester ID of the result
- rsp_data_o  output  16  result
- rsp_err_o  output  1  result belongs to an illegal opcode
- busy_o  output  1  any operation in flight

Behaviour:
- Reset (async, reset_n_i=0): all ALU drive outputs 0; rsp_valid_o/rsp_id_o/rsp_data_o/rsp_err_o 0; busy_o 0; RR pointer = NREQ-1, so requester 0 has first priority; tracking pipe cleared.
- Reset mid-operation discards in-flight operations; no response is emitted for them.
- Arbitration:
  - Combinational, no state machine besides the pointer.
  - Priority starts at (ptr+1) mod NREQ and wraps through NREQ-1 to 0.
  - Grant = first requester with req_valid_i=1; none if hold_i=1.
  - req_ready_o[g]=1 for the granted index only; handshake = valid & ready in the same cycle.
  - Pointer updates to g only on handshake.
  - Requester must hold valid/data/inst stable until ready; dropping valid early is illegal (not checked).
  - Every cycle without hold accepts exactly one request if any is valid: full throughput, 1 op/cycle.
- Issue stage (cycle t = handshake):
  - At end of t: alu_*_o load the granted operands/opcode.
  - In a cycle with no handshake, alu_*_o load 0 (opcode 000); the result is ignored.
  - Tag register loads {1, g, illegal}, with illegal = (opcode == 3'b111).
- Tracking:
  - Tag shift register of depth ALU_LAT+1 advances every cycle, mirroring the ALU pipeline.
  - ALU result for the op issued at t appears on alu_data_i during cycle t+1+ALU_LAT.
- Response (registered): rsp_* update at end of cycle t+1+ALU_LAT, visible in cycle t+2+ALU_LAT (t+4 with default).
  - rsp_data_o = alu_data_i, or 16'h0000 when the tag is illegal.
  - rsp_err_o = tag illegal.
  - rsp_id_o = tag ID.
  - When no valid tag: rsp_valid_o=0; rsp_data_o/rsp_id_o/rsp_err_o hold their previous values.
  - No response back-pressure: consumers must accept every pulse.
- Ordering: responses return strictly in issue order, one per cycle at most.
- busy_o = OR of all tag valid bits plus the rsp_valid_o stage.
- Simultaneous events:
  - hold_i rising while requests pend: no grant that cycle; in-flight ops still complete.
  - hold_i has no effect on the tracking pipe.
  - Same requester re-requesting back-to-back: granted again only when no other requester is valid.
- Width rules: IDs are 0..NREQ-1; results are 16-bit as produced by the ALU; no truncation.

Decomposition:
- Package alu_ctrl_pkg:
  - typedef enum logic [2:0] alu_op_e: ADD=0, SUB_BA=1, MUL=2, NOT_A=3, XOR=4, ABS_A=5, HSUB=6, ILLEGAL=7
  - localparam ALU_LATENCY=2
  - typedef struct alu_tag_t {valid, id, illegal}
- Sub-module rr_arbiter:
  - Parameter N; inputs req, ptr, hold; outputs one-hot grant and grant index.
  - Purely combinational; the pointer register stays in alu_rr_sched.

Test Plan:
1. Reset, then only req0 valid with a=8'h05, b=8'h03, inst=ADD at t=2 -> req_ready_o=4'b0001 at t=2; at t=6 rsp_valid_o=1, rsp_id_o=0, rsp_data_o=16'h0008, rsp_err_o=0.
2. All 4 requesters valid continuously (req i: a=i+1, b=8'h10, inst=MUL) -> grants 0,1,2,3,0,... one per cycle; responses at t+4 with IDs 0,1,2,3 and data 16'h0010, 16'h0020, 16'h0030, 16'h0040.
3. req2 inst=3'b111, a=8'hFF -> accepted, response 4 cycles later with rsp_err_o=1, rsp_data_o=16'h0000, rsp_id_o=2.
4. req1 and req3 valid, hold_i=1 for 3 cycles, then 0 -> req_ready_o=0 while held, busy_o drops after in-flight ops drain; after release grant goes to req1, then req3.
5. req0 SUB_BA a=8'h05, b=8'h03 -> rsp_data_o=16'hFFFE; HSUB same operands -> 16'hFFFF.
6. Issue 3 ops back-to-back, assert reset_n_i=0 one cycle after the last issue -> all outputs 0 immediately; no rsp_valid_o pulse after reset release; next grant goes to requester 0 first.
